ram_port_arbiter: RTL

//  Round-robin arbiter sharing the 8x16 dual-port RAM between NUM_REQ clients, on one clock.
//  The write port and the read port are arbitrated independently.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 63 ++++++
 rtl/ram_port_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the RAM port arbiter.
// Optional feature macro: RAM_ARB_WR_BYPASS_EN (see ram_port_arbiter).
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 3;
    localparam int RAM_DATA_W = 16;
    localparam int RAM_DEPTH  = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search
// starts at an internal pointer that moves past each winner.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_any
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;

    always_comb begin : search
        logic [IW:0]   s;
        logic [IW-1:0] idx;
        logic          found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        s      = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr} + (IW+1)'(k);
            if (s >= (IW+1)'(N)) begin
                s = s - (IW+1)'(N);
            end
            idx = s[IW-1:0];
            if (!found && req[idx] && !rst) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
        gnt_any = found;
    end

    always_comb begin
        ptr_nxt = ptr;
        if (gnt_any) begin
            if (gnt_id == IW'(N - 1)) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one dual-port RAM between NUM_REQ clients; write and read
// ports arbitrated independently. Macro: RAM_ARB_WR_BYPASS_EN.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         wr_req,
    input  logic [NUM_REQ*3-1:0]       wr_addr_in,
    input  logic [NUM_REQ*16-1:0]      wr_data_in,
    output logic [NUM_REQ-1:0]         wr_gnt,
    input  logic [NUM_REQ-1:0]         rd_req,
    input  logic [NUM_REQ*3-1:0]       rd_addr_in,
    output logic [NUM_REQ-1:0]         rd_gnt,
    output logic                       rd_rsp_valid,
    output logic [ID_W-1:0]            rd_rsp_id,
    output logic [15:0]                rd_rsp_data,
    output logic                       ram_wr_en,
    output logic [2:0]                 ram_wr_addr,
    output logic [15:0]                ram_wr_data,
    output logic [2:0]                 ram_rd_addr,
    input  logic [15:0]                ram_rd_data
);

    logic [ID_W-1:0] wr_id;
    logic [ID_W-1:0] rd_id;
    logic            wr_any;
    logic            rd_any;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wr_req),
        .gnt     (wr_gnt),
        .gnt_id  (wr_id),
        .gnt_any (wr_any)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rd_req),
        .gnt     (rd_gnt),
        .gnt_id  (rd_id),
        .gnt_any (rd_any)
    );

    // One-hot AND-OR muxes; all-zero when nothing is granted
    always_comb begin
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_rd_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                ram_wr_addr = wr_addr_in[RAM_ADDR_W*i +: RAM_ADDR_W];
                ram_wr_data = wr_data_in[RAM_DATA_W*i +: RAM_DATA_W];
            end
            if (rd_gnt[i]) begin
                ram_rd_addr = rd_addr_in[RAM_ADDR_W*i +: RAM_ADDR_W];
            end
        end
    end

    assign ram_wr_en = wr_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_id    <= '0;
        end else begin
            rd_rsp_valid <= rd_any;
            if (rd_any) begin
                rd_rsp_id <= rd_id;
            end
        end
    end

`ifdef RAM_ARB_WR_BYPASS_EN
    logic        byp_hit;
    logic [15:0] byp_data;
    logic        collide;

    assign collide = wr_any && rd_any && (ram_wr_addr == ram_rd_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
        end else begin
            byp_hit  <= collide;
            byp_data <= collide ? ram_wr_data : '0;
        end
    end

    // RAM returns pre-write contents on collision; forward the new data
    assign rd_rsp_data = byp_hit ? byp_data : ram_rd_data;
`else
    assign rd_rsp_data = ram_rd_data;
`endif

endmodule
